program_loader: RTL and testbench

//   Byte-stream program loader sitting directly upstream of simple_processor.

---
 rtl/program_loader.sv | 146 ++++++++++++++
 tb/tb_program_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: header N, then N 3-byte words -> program_in/write, then start for START_CYCLES.
// Latency: write is high the cycle after the last byte of a word; best case 4 cycles per word.
// Backpressure: in_ready is low in WR and RUN, and upstream holds its byte; abort drops any byte offered that cycle.
module program_loader #(
  parameter int WORD_W       = 23,
  parameter int START_CYCLES = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic [WORD_W-1:0] program_in,
  output logic              write,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              fmt_err
);

  localparam int RUN_W = (START_CYCLES > 1) ? $clog2(START_CYCLES + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(START_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_B2,
    S_B1,
    S_B0,
    S_WR,
    S_RUN
  } state_t;

  state_t           state;
  logic [7:0]       word_cnt;
  logic [14:0]      hi_bytes;   // {b2[6:0], b1} of the word being assembled
  logic             bad;        // current word had b2[7] set
  logic [RUN_W-1:0] run_cnt;
  logic             write_r;
  logic             start_r;
  logic             done_r;
  logic             xfer;

  assign xfer = in_valid & in_ready;

  // abort must silence the pulses in the very cycle it is asserted
  assign write = write_r & ~abort;
  assign start = start_r & ~abort;
  assign done  = done_r  & ~abort;

  // Loader FSM: frame parsing, word assembly, write pulse and start window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      program_in <= '0;
      write_r    <= 1'b0;
      start_r    <= 1'b0;
      done_r     <= 1'b0;
      fmt_err    <= 1'b0;
      word_cnt   <= 8'd0;
      hi_bytes   <= 15'd0;
      bad        <= 1'b0;
      run_cnt    <= '0;
    end else if (abort) begin
      // partial word and counter are dropped; program_in and fmt_err survive
      state    <= S_IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      write_r  <= 1'b0;
      start_r  <= 1'b0;
      done_r   <= 1'b0;
      word_cnt <= 8'd0;
      bad      <= 1'b0;
      run_cnt  <= '0;
    end else begin
      write_r <= 1'b0;
      done_r  <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          // a zero header is swallowed and leaves the loader idle
          if (xfer && in_data != 8'd0) begin
            word_cnt <= in_data;
            fmt_err  <= 1'b0;
            busy     <= 1'b1;
            state    <= S_B2;
          end
        end
        S_B2: begin
          if (xfer) begin
            hi_bytes[14:8] <= in_data[6:0];
            bad            <= in_data[7];
            if (in_data[7]) fmt_err <= 1'b1;
            state <= S_B1;
          end
        end
        S_B1: begin
          if (xfer) begin
            hi_bytes[7:0] <= in_data;
            state         <= S_B0;
          end
        end
        S_B0: begin
          if (xfer) begin
            program_in <= WORD_W'({hi_bytes, in_data});
            write_r    <= ~bad;
            in_ready   <= 1'b0;
            state      <= S_WR;
          end
        end
        S_WR: begin
          word_cnt <= word_cnt - 8'd1;
          if (word_cnt == 8'd1) begin
            state   <= S_RUN;
            start_r <= 1'b1;
            run_cnt <= '0;
            done_r  <= (START_CYCLES == 1);
          end else begin
            in_ready <= 1'b1;
            state    <= S_B2;
          end
        end
        S_RUN: begin
          if (run_cnt == RUN_LAST) begin
            state    <= S_IDLE;
            start_r  <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
            done_r  <= ((run_cnt + 1'b1) == RUN_LAST);
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          start_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int WORD_W       = 23;
  localparam int START_CYCLES = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              abort;
  logic [WORD_W-1:0] program_in;
  logic              write;
  logic              start;
  logic              busy;
  logic              done;
  logic              fmt_err;

  int checks = 0;
  int errors = 0;

  logic [22:0] exp_wr[$];
  int          exp_run[$];

  program_loader #(.WORD_W(WORD_W), .START_CYCLES(START_CYCLES)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .program_in(program_in),
    .write(write), .start(start), .busy(busy), .done(done), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // scoreboard monitor: pops expected words / run lengths as the DUT presents them
  task automatic monitor();
    int run_len = 0;
    logic [22:0] e;
    int er;
    forever begin
      @(negedge clk);
      if (write) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: program_in=%06h, no write expected", program_in);
        end else begin
          e = exp_wr.pop_front();
          chk("write_word", 32'(program_in), 32'(e));
        end
      end
      if (start) run_len++; else run_len = 0;
      if (start && run_len == START_CYCLES + 1) begin
        checks++; errors++;
        $display("FAIL start_too_long: start high %0d cycles, required %0d", run_len, START_CYCLES);
      end
      if (done) begin
        chk1("start_with_done", start, 1'b1);
        if (exp_run.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done after %0d start cycles, none expected", run_len);
        end else begin
          er = exp_run.pop_front();
          chk("done_run_length", run_len, er);
        end
      end
    end
  endtask

  // offer one byte, hold until accepted, then idle for gap cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte %02h not accepted, in_ready=%0b", b, in_ready);
    end
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string name);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk1(name, busy, 1'b0);
    @(posedge clk); #1;
  endtask

  logic [7:0] t3_bytes[7] = '{8'h02, 8'h2A, 8'hAA, 8'hAA, 8'h7F, 8'hFF, 8'hFF};
  int         t3_gaps[7]  = '{1, 2, 3, 0, 1, 2, 0};

  initial begin
    reset = 1'b0; in_data = 8'h00; in_valid = 1'b0; abort = 1'b0;
    fork
      monitor();
    join_none

    // 1: reset values, then idle after release
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_write", write, 1'b0);
    chk1("rst_start", start, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_fmt_err", fmt_err, 1'b0);
    chk("rst_program_in", 32'(program_in), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk1("idle_in_ready", in_ready, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_start", start, 1'b0);
    chk1("idle_write", write, 1'b0);
    @(posedge clk); #1;

    // 2: single word back-to-back
    exp_wr.push_back(23'h123456);
    exp_run.push_back(START_CYCLES);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    chk1("write_latency", write, 1'b1);
    wait_idle("t2_busy_cleared");
    chk1("t2_start_low", start, 1'b0);

    // 3: two words with valid gaps, including a byte held across WR
    exp_wr.push_back(23'h2AAAAA);
    exp_wr.push_back(23'h7FFFFF);
    exp_run.push_back(START_CYCLES);
    for (int i = 0; i < 7; i++) send_byte(t3_bytes[i], t3_gaps[i]);
    wait_idle("t3_busy_cleared");

    // 4: bad word sets fmt_err, no write, run still happens
    exp_run.push_back(START_CYCLES);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hAA, 0);
    chk1("t4_fmt_err_set", fmt_err, 1'b1);
    chk1("t4_no_write", write, 1'b0);
    wait_idle("t4_busy_cleared");
    chk1("t4_fmt_err_sticky", fmt_err, 1'b1);

    // 5: abort mid-word, with a byte offered in the same cycle
    send_byte(8'h03, 0);
    chk1("t5_fmt_err_cleared", fmt_err, 1'b0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    abort = 1'b1; in_data = 8'h56; in_valid = 1'b1;
    @(negedge clk);
    chk1("t5_abort_write", write, 1'b0);
    @(posedge clk); #1 abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk1("t5_abort_busy", busy, 1'b0);
    chk1("t5_abort_in_ready", in_ready, 1'b1);
    chk("t5_program_in_kept", 32'(program_in), 32'h2AAAAA);
    @(posedge clk); #1;
    exp_wr.push_back(23'h000007);
    exp_run.push_back(START_CYCLES);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h07, 0);
    wait_idle("t5_busy_cleared");

    // 6: reset during the 4th RUN cycle
    exp_wr.push_back(23'h000001);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (start) break;
    end
    chk1("t6_run_started", start, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("t6_rst_start", start, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_write", write, 1'b0);
    chk1("t6_rst_done", done, 1'b0);
    chk1("t6_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    chk1("t6_hdr0_busy", busy, 1'b0);
    chk1("t6_hdr0_in_ready", in_ready, 1'b1);
    chk("t6_program_in_reset", 32'(program_in), 32'd0);

    repeat (5) @(negedge clk);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("run_queue_empty", exp_run.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
